// File: rtl/framing_ctrl_if.sv
// Sample-stream and framing-memory signals of the MFCC framing controller.
// master = the controller, slave = its environment (source, sink and memory).
interface framing_ctrl_if #(
    parameter int BITS = 12,
    parameter int AW   = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            mem_wen;
    logic [AW-1:0]   mem_a;
    logic [BITS-1:0] mem_d;
    logic [BITS-1:0] mem_q;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic            out_first;
    logic            out_last;

    modport master (
        input  in_valid, in_data, mem_q, out_ready,
        output in_ready, mem_wen, mem_a, mem_d,
        output out_valid, out_data, out_first, out_last
    );

    modport slave (
        output in_valid, in_data, mem_q, out_ready,
        input  in_ready, mem_wen, mem_a, mem_d,
        input  out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/framing_ctrl.sv
// Framing controller: writes samples into a circular framing memory and, every HOP
// new samples, streams back one FRAME_LEN frame oldest-first to the windowing stage.
module framing_ctrl #(
    parameter int BITS      = 12,
    parameter int FRAME_LEN = 128,
    parameter int HOP       = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    framing_ctrl_if.master bus
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(FRAME_LEN + 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]      state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [CW-1:0]   new_cnt;
    logic [CW-1:0]   new_cnt_nxt;
    logic [CW-1:0]   rd_cnt;
    logic            primed;
    logic            out_valid;
    logic            out_first;
    logic            out_last;
    logic [BITS-1:0] out_data;
    logic            accept;
    logic            trigger;
    logic            load;
    logic            last_hs;

    always_comb begin
        accept      = (state == FILL) && bus.in_valid;
        wr_ptr_nxt  = wr_ptr + AW'(1);
        new_cnt_nxt = new_cnt + CW'(1);
        // Until the memory holds one full frame, the first frame waits for FRAME_LEN samples.
        trigger     = accept && (primed ? (new_cnt_nxt == CW'(HOP))
                                        : (new_cnt_nxt == CW'(FRAME_LEN)));
        load        = (state == READ) && (!out_valid || bus.out_ready)
                      && (rd_cnt < CW'(FRAME_LEN));
        last_hs     = out_valid && bus.out_ready && out_last;
    end

    always_comb begin
        bus.in_ready = (state == FILL);
        bus.mem_wen  = accept;
        bus.mem_a    = (state == FILL) ? wr_ptr : rd_ptr;
        bus.mem_d    = bus.in_data;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_first = out_first;
    assign bus.out_last  = out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            new_cnt   <= '0;
            rd_cnt    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                wr_ptr  <= wr_ptr_nxt;
                new_cnt <= trigger ? '0 : new_cnt_nxt;
                if (trigger) begin
                    primed <= 1'b1;
                    state  <= READ;
                    // The slot just past the newest sample holds the oldest one.
                    rd_ptr <= wr_ptr_nxt;
                    rd_cnt <= '0;
                end
            end

            // Output register reloads on the same edge it hands off, so there is no bubble.
            if (load) begin
                out_data  <= bus.mem_q;
                out_valid <= 1'b1;
                out_first <= (rd_cnt == '0);
                out_last  <= (rd_cnt == CW'(FRAME_LEN - 1));
                rd_ptr    <= rd_ptr + AW'(1);
                rd_cnt    <= rd_cnt + CW'(1);
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

            if (last_hs) begin
                state <= FILL;
            end
        end
    end
endmodule
